// File: rtl/code_bus_pkg.sv
// Shared types and sizes for the code bus master and its address generator.
package code_bus_pkg;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 8192;
  localparam int PTR_W     = 13;
  localparam int LEN_W     = 8;
  localparam int CNT_W     = 9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_DRAIN = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } state_t;
endpackage

// File: rtl/code_bus_addr_gen.sv
// Wrapping 13-bit memory pointer plus 9-bit remaining-beat counter.
module code_bus_addr_gen
  import code_bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PTR_W-1:0] start_addr,
  input  logic [LEN_W-1:0] beats_m1,
  input  logic             step,
  output logic [PTR_W-1:0] ptr,
  output logic             last
);
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Counter holds beats still to transfer, so len=255 loads 256.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      ptr_reg <= start_addr;
      cnt_reg <= {1'b0, beats_m1} + CNT_W'(1);
    end else if (step) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign ptr  = ptr_reg;
  assign last = (cnt_reg == CNT_W'(1));
endmodule

// File: rtl/code_bus_master.sv
// Burst master bridging a write/read beat interface onto a shared-data-bus memory.
module code_bus_master
  import code_bus_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              rw,
  output logic [ADDR_W-1:0] add_bus,
  inout  wire  [DATA_W-1:0] data_bus
);
  state_t            state_reg, state_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;
  logic              load, step, rd_sample, last;
  logic [PTR_W-1:0]  ptr;
  logic              addr_hi_unused;

  assign addr_hi_unused = ^addr[ADDR_W-1:PTR_W];

  code_bus_addr_gen u_addr_gen (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .start_addr (addr[PTR_W-1:0]),
    .beats_m1   (len),
    .step       (step),
    .ptr        (ptr),
    .last       (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    rd_sample  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          load       = 1'b1;
          state_next = we ? WR : RD;
        end
      end
      WR: begin
        if (wvalid) begin
          step = 1'b1;
          if (last) state_next = DONE;
        end
      end
      RD: begin
        // A new sample is taken whenever the output slot is free or being emptied.
        if (!rvalid_reg || rready) begin
          rd_sample = 1'b1;
          step      = 1'b1;
          if (last) state_next = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (rvalid_reg && rready) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else if (rd_sample) begin
      rdata_reg  <= data_bus;
      rvalid_reg <= 1'b1;
    end else if (rvalid_reg && rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  // Write strobe is purely combinational from state, so reset drops it at once.
  assign wready   = (state_reg == WR) && wvalid;
  assign rw       = !wready;
  assign data_bus = rw ? {DATA_W{1'bz}} : wdata;
  assign add_bus  = {{(ADDR_W-PTR_W){1'b0}}, ptr};
  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
endmodule

// File: tb/tb_code_bus_master.sv
// Randomized scoreboard bench for code_bus_master with a flat memory model on the shared bus.
module tb_code_bus_master;
  logic        clock = 1'b0;
  logic        reset_n, req, we, wvalid, rready;
  logic [15:0] addr;
  logic [7:0]  len, wdata;
  wire         wready, rvalid, busy, done, rw;
  wire  [7:0]  rdata;
  wire  [15:0] add_bus;
  wire  [7:0]  data_bus;

  logic [7:0] phys_mem [8192];
  logic [7:0] ref_mem  [8192];

  typedef struct { logic [12:0] a; logic [7:0] d; } wbeat_t;
  wbeat_t     wq[$];
  logic [7:0] rq[$];
  logic [7:0] wr_data[$];

  int checks = 0, errors = 0;
  int done_seen = 0, done_exp = 0, hs_count = 0;
  logic prev_done = 1'b0;

  always #5 clock = ~clock;

  code_bus_master dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .rready(rready), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .done(done), .rw(rw), .add_bus(add_bus), .data_bus(data_bus)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'((i * 37 + 5) ^ (i >> 5));
  endfunction

  // Asynchronous-read memory: drives the bus while the master reads, stores on write edges.
  assign data_bus = rw ? phys_mem[add_bus[12:0]] : 8'hzz;
  initial begin
    for (int i = 0; i < 8192; i++) phys_mem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (reset_n && !rw) phys_mem[add_bus[12:0]] <= data_bus;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a beat.
  always @(negedge clock) begin
    if (reset_n) begin
      if (wready) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wbeat_t b;
          b = wq.pop_front();
          chk("write_addr", int'(add_bus), int'(b.a));
          chk("write_data", int'(data_bus), int'(b.d));
        end
      end
      if (rvalid && rready) begin
        hs_count++;
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_data", int'(rdata), int'(rq.pop_front()));
      end
      chk("rw_vs_wready", int'(rw), int'(!wready));
      chk("addr_hi_zero", int'(add_bus[15:13]), 0);
      if (done) begin
        done_seen++;
        chk("done_one_cycle", int'(prev_done), 0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 4000) begin tick(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic w, input int a, input int l);
    wait_idle();
    req = 1'b1; we = w; addr = 16'(a); len = 8'(l);
    tick();
    req = 1'b0; we = 1'($urandom); addr = 16'($urandom); len = 8'($urandom);
    chk("busy_rise", int'(busy), 1);
  endtask

  // mode: 0 = wvalid always, 1 = random gaps, 2 = alternate 1,0,1,0
  task automatic do_write(input int a, input int l, input int mode);
    logic [7:0] d[$];
    int i = 0, k = 0;
    logic v;
    a = a & 8191;
    for (int j = 0; j <= l; j++) begin
      d.push_back(j < wr_data.size() ? wr_data[j] : 8'($urandom));
      wq.push_back('{13'((a + j) % 8192), d[j]});
      ref_mem[(a + j) % 8192] = d[j];
    end
    wr_data.delete();
    done_exp++;
    issue(1'b1, a, l);
    while (i <= l && k < 4000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k % 2 == 0);
      wvalid = v;
      wdata  = v ? d[i] : ~d[i];
      @(negedge clock);
      if (!v) begin
        chk("gap_rw", int'(rw), 1);
        chk("gap_bus_released", int'(data_bus), int'(phys_mem[add_bus[12:0]]));
      end
      tick();
      if (v) i++;
      k++;
    end
    if (i <= l) chk("write_timeout", 1, 0);
    wvalid = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input int a, input int l, input int mode);
    int n = 0;
    a = a & 8191;
    for (int j = 0; j <= l; j++) rq.push_back(ref_mem[(a + j) % 8192]);
    done_exp++;
    rready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    issue(1'b0, a, l);
    while (busy && n < 4000) begin
      rready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (busy) chk("read_timeout", 1, 0);
    rready = 1'b1;
  endtask

  initial begin
    int hs0, diffs;
    logic [15:0] a_hold;
    logic [7:0]  d_hold;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    reset_n = 1'b0; req = 0; we = 0; addr = 0; len = 0; wdata = 0; wvalid = 0; rready = 1;
    #1;
    chk("reset_rw", int'(rw), 1);
    chk("reset_add_bus", int'(add_bus), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rvalid", int'(rvalid), 0);
    chk("reset_rdata", int'(rdata), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single write then read with latency check.
    wr_data.push_back(8'hA5);
    do_write(16'h0100, 0, 0);
    rq.push_back(ref_mem[16'h0100]);
    done_exp++;
    rready = 1'b1;
    issue(1'b0, 16'h0100, 0);
    chk("lat_rvalid_early", int'(rvalid), 0);
    chk("lat_add_bus", int'(add_bus), 16'h0100);
    tick();
    chk("lat_rvalid", int'(rvalid), 1);
    chk("lat_rdata", int'(rdata), 8'hA5);
    wait_idle();

    // Wrapping write burst.
    wr_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(16'h1FFE, 3, 0);
    chk("wrap_1ffe", int'(phys_mem[13'h1FFE]), 8'h11);
    chk("wrap_1fff", int'(phys_mem[13'h1FFF]), 8'h22);
    chk("wrap_0000", int'(phys_mem[13'h0000]), 8'h33);
    chk("wrap_0001", int'(phys_mem[13'h0001]), 8'h44);

    // Backpressure: rready low for 3 cycles after the first rvalid.
    hs0 = hs_count;
    for (int j = 0; j < 4; j++) rq.push_back(ref_mem[16'h0200 + j]);
    done_exp++;
    rready = 1'b0;
    issue(1'b0, 16'h0200, 3);
    tick();
    chk("bp_first_rvalid", int'(rvalid), 1);
    a_hold = add_bus; d_hold = rdata;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("bp_add_hold", int'(add_bus), int'(a_hold));
      chk("bp_rdata_hold", int'(rdata), int'(d_hold));
    end
    rready = 1'b1;
    wait_idle();
    chk("bp_handshakes", hs_count - hs0, 4);

    // Write gaps 1,0,1,0.
    do_write(16'h0400, 3, 2);
    do_read(16'h0400, 3, 0);

    // Request pulsed while busy must be ignored.
    for (int j = 0; j < 8; j++) rq.push_back(ref_mem[16'h0500 + j]);
    done_exp++;
    rready = 1'b0;
    issue(1'b0, 16'h0500, 7);
    tick();
    req = 1'b1; we = 1'b1; addr = 16'h0555; len = 8'd2;
    tick();
    req = 1'b0;
    rready = 1'b1;
    wait_idle();

    // Reset in the middle of a read burst.
    for (int j = 0; j < 16; j++) rq.push_back(ref_mem[16'h0600 + j]);
    issue(1'b0, 16'h0600, 15);
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rw", int'(rw), 1);
    chk("mid_rst_add_bus", int'(add_bus), 0);
    chk("mid_rst_rvalid", int'(rvalid), 0);
    chk("mid_rst_rdata", int'(rdata), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_wready", int'(wready), 0);
    rq.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset during beat 2 of a 4-beat write: only beats 0-1 land.
    for (int j = 0; j < 2; j++) begin
      wq.push_back('{13'(16'h0300 + j), 8'(8'hC0 + j)});
      ref_mem[16'h0300 + j] = 8'(8'hC0 + j);
    end
    issue(1'b1, 16'h0300, 3);
    wvalid = 1'b1;
    wdata = 8'hC0; tick();
    wdata = 8'hC1; tick();
    wdata = 8'hC2;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rw", int'(rw), 1);
    chk("abort_wready", int'(wready), 0);
    wvalid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    for (int j = 0; j < 4; j++)
      chk("abort_mem", int'(phys_mem[16'h0300 + j]), int'(ref_mem[16'h0300 + j]));

    // Full-length bursts across the wrap point.
    do_write(16'hFF80, 255, 1);
    do_read(16'hFF80, 255, 1);

    // Randomized mix.
    for (int t = 0; t < 40; t++) begin
      int a, l;
      a = int'($urandom_range(0, 65535));
      l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1);
      else                          do_read(a, l, 1);
    end
    wait_idle();
    tick(); tick();

    chk("done_count", done_seen, done_exp);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    diffs = 0;
    for (int i = 0; i < 8192; i++) if (phys_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", diffs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
